// File: rtl/pm_loader_pkg.sv
// Shared constants for the PicoBlaze program loader: FSM encodings, frame marker,
// write-enable pattern and the 3-byte instruction packer.
package pm_loader_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LEN_HI = 3'd1;
   localparam logic [2:0] ST_LEN_LO = 3'd2;
   localparam logic [2:0] ST_B0     = 3'd3;
   localparam logic [2:0] ST_B1     = 3'd4;
   localparam logic [2:0] ST_B2     = 3'd5;
   localparam logic [2:0] ST_WRITE  = 3'd6;
   localparam logic [2:0] ST_CSUM   = 3'd7;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam logic [3:0] PM_WE_ALL     = 4'b1111;

   // b0 supplies only instruction bits [17:16]; its upper six bits are don't-care
   function automatic logic [17:0] pack_word(input logic [1:0] hi,
                                             input logic [7:0] mid,
                                             input logic [7:0] lo);
      return {hi, mid, lo};
   endfunction

endpackage

// File: rtl/pm_loader_timeout.sv
// Idle watchdog for the loader: reloads on every byte handshake, counts down while
// a frame is waiting for input, and flags expiry on its last count.
module pm_loader_timeout #(
   parameter int unsigned LOAD_VAL = 16,
   parameter int          CNT_W    = $clog2(LOAD_VAL + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_load,
   input  logic i_en,
   output logic o_expire
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (i_clr) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (i_load) begin
         r_cnt <= CNT_W'(LOAD_VAL);
      end else if (i_en && (r_cnt != {CNT_W{1'b0}})) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // Expiry is taken on the edge that would move the count from 1 to 0
   assign o_expire = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/pm_loader.sv
// Serial program loader: unpacks a framed UART byte stream into 18-bit PicoBlaze
// instructions, writes them to the BRAM and holds the CPU in reset until a good load.
module pm_loader
   import pm_loader_pkg::*;
#(
   parameter int          ADDR_W      = 10,
   parameter int          INSTR_W     = 18,
   parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   output logic               o_rx_ready,
   output logic [ADDR_W-1:0]  o_pm_addr,
   output logic [INSTR_W-1:0] o_pm_wdata,
   output logic [3:0]         o_pm_we,
   output logic               o_cpu_reset,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_error,
   output logic [ADDR_W:0]    o_words_loaded
);

   localparam logic [15:0] LEN_MAX = 16'((1 << ADDR_W) - 1);

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic               r_rx_ready;
   logic [7:0]         r_len_hi;
   logic [ADDR_W-1:0]  r_len;
   logic [1:0]         r_b0;
   logic [7:0]         r_b1;
   logic [7:0]         r_sum;
   logic [ADDR_W:0]    r_idx;
   logic [ADDR_W-1:0]  r_pm_addr;
   logic [INSTR_W-1:0] r_pm_wdata;
   logic [3:0]         r_pm_we;
   logic               r_cpu_reset;
   logic               r_busy;
   logic               r_done;
   logic               r_error;
   logic [ADDR_W:0]    r_words_loaded;

   logic               w_hs;
   logic               w_active;
   logic               w_expire;
   logic               w_tmo;
   logic               w_sync_start;
   logic [15:0]        w_len16;
   logic               w_len_err;
   logic [7:0]         w_sum_fin;
   logic               w_csum_ok;
   logic               w_csum_bad;
   logic               w_last;

   assign w_hs         = i_rx_valid & r_rx_ready;
   assign w_active     = (r_state != ST_IDLE) && (r_state != ST_WRITE);
   assign w_tmo        = w_active && !w_hs && w_expire;
   assign w_sync_start = (r_state == ST_IDLE) && w_hs && (i_rx_data == SYNC_BYTE);
   assign w_len16      = {r_len_hi, i_rx_data};
   assign w_len_err    = (r_state == ST_LEN_LO) && w_hs && (w_len16 > LEN_MAX);
   assign w_sum_fin    = r_sum + i_rx_data;
   assign w_csum_ok    = (r_state == ST_CSUM) && w_hs && (w_sum_fin == 8'h00);
   assign w_csum_bad   = (r_state == ST_CSUM) && w_hs && (w_sum_fin != 8'h00);
   assign w_last       = (r_idx[ADDR_W-1:0] == r_len);

   pm_loader_timeout #(
      .LOAD_VAL (TIMEOUT_CYC)
   ) u_timeout (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    ((r_state == ST_IDLE) && !w_hs),
      .i_load   (w_hs),
      .i_en     (w_active),
      .o_expire (w_expire)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_sync_start) w_state_nxt = ST_LEN_HI; else w_state_nxt = ST_IDLE;
         ST_LEN_HI: if (w_tmo) w_state_nxt = ST_IDLE; else if (w_hs) w_state_nxt = ST_LEN_LO;
                    else w_state_nxt = ST_LEN_HI;
         ST_LEN_LO: if (w_tmo || w_len_err) w_state_nxt = ST_IDLE;
                    else if (w_hs) w_state_nxt = ST_B0; else w_state_nxt = ST_LEN_LO;
         ST_B0:     if (w_tmo) w_state_nxt = ST_IDLE; else if (w_hs) w_state_nxt = ST_B1;
                    else w_state_nxt = ST_B0;
         ST_B1:     if (w_tmo) w_state_nxt = ST_IDLE; else if (w_hs) w_state_nxt = ST_B2;
                    else w_state_nxt = ST_B1;
         ST_B2:     if (w_tmo) w_state_nxt = ST_IDLE; else if (w_hs) w_state_nxt = ST_WRITE;
                    else w_state_nxt = ST_B2;
         ST_WRITE:  if (w_last) w_state_nxt = ST_CSUM; else w_state_nxt = ST_B0;
         ST_CSUM:   if (w_tmo || w_hs) w_state_nxt = ST_IDLE; else w_state_nxt = ST_CSUM;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Ready is a pure function of the next state, so rx_valid never reaches it combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_ready <= 1'b1;
      end else begin
         r_rx_ready <= (w_state_nxt != ST_WRITE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len_hi <= 8'h00;
         r_len    <= {ADDR_W{1'b0}};
         r_b0     <= 2'b00;
         r_b1     <= 8'h00;
         r_sum    <= 8'h00;
      end else if (w_hs) begin
         case (r_state)
            ST_IDLE:   r_sum    <= 8'h00;
            ST_LEN_HI: r_len_hi <= i_rx_data;
            ST_LEN_LO: r_len    <= w_len16[ADDR_W-1:0];
            ST_B0: begin
               r_b0  <= i_rx_data[1:0];
               r_sum <= w_sum_fin;
            end
            ST_B1: begin
               r_b1  <= i_rx_data;
               r_sum <= w_sum_fin;
            end
            ST_B2:     r_sum    <= w_sum_fin;
            default:   r_sum    <= r_sum;
         endcase
      end else begin
         r_sum <= r_sum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pm_we    <= 4'b0000;
         r_pm_addr  <= {ADDR_W{1'b0}};
         r_pm_wdata <= {INSTR_W{1'b0}};
      end else if ((r_state == ST_B2) && w_hs) begin
         r_pm_we    <= PM_WE_ALL;
         r_pm_addr  <= r_idx[ADDR_W-1:0];
         r_pm_wdata <= pack_word(r_b0, r_b1, i_rx_data);
      end else begin
         r_pm_we    <= 4'b0000;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= {(ADDR_W+1){1'b0}};
      end else if (w_sync_start) begin
         r_idx <= {(ADDR_W+1){1'b0}};
      end else if (r_state == ST_WRITE) begin
         r_idx <= r_idx + (ADDR_W+1)'(1);
      end else begin
         r_idx <= r_idx;
      end
   end

   // cpu_reset is only ever released by a good checksum; failed frames leave it set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy         <= 1'b0;
         r_cpu_reset    <= 1'b0;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
         r_words_loaded <= {(ADDR_W+1){1'b0}};
      end else begin
         r_done  <= w_csum_ok;
         r_error <= w_len_err | w_csum_bad | w_tmo;
         if (w_sync_start) begin
            r_busy      <= 1'b1;
            r_cpu_reset <= 1'b1;
         end else if (w_csum_ok) begin
            r_busy      <= 1'b0;
            r_cpu_reset <= 1'b0;
         end else if (w_len_err || w_csum_bad || w_tmo) begin
            r_busy      <= 1'b0;
         end else begin
            r_busy      <= r_busy;
         end
         if (w_csum_ok || w_csum_bad || w_len_err || w_tmo) begin
            r_words_loaded <= r_idx;
         end else begin
            r_words_loaded <= r_words_loaded;
         end
      end
   end

   assign o_rx_ready     = r_rx_ready;
   assign o_pm_addr      = r_pm_addr;
   assign o_pm_wdata     = r_pm_wdata;
   assign o_pm_we        = r_pm_we;
   assign o_cpu_reset    = r_cpu_reset;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_error        = r_error;
   assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_pm_loader.sv
// Scoreboard bench for pm_loader: directed frames push expected writes/events,
// a negedge monitor pops and compares whenever the loader writes or reports.
module tb_pm_loader;

   localparam int AW = 10;
   localparam int IW = 18;

   logic          clk;
   logic          rst_n;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          o_rx_ready;
   logic [AW-1:0] o_pm_addr;
   logic [IW-1:0] o_pm_wdata;
   logic [3:0]    o_pm_we;
   logic          o_cpu_reset;
   logic          o_busy;
   logic          o_done;
   logic          o_error;
   logic [AW:0]   o_words_loaded;

   int n_tests = 0;
   int n_fail  = 0;
   int n_we    = 0;

   logic [AW+IW-1:0] exp_wr[$];
   logic [AW+2:0]    exp_ev[$];
   logic [7:0]       fb[$];

   pm_loader #(
      .ADDR_W(AW), .INSTR_W(IW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_rx_ready(o_rx_ready), .o_pm_addr(o_pm_addr), .o_pm_wdata(o_pm_wdata),
      .o_pm_we(o_pm_we), .o_cpu_reset(o_cpu_reset), .o_busy(o_busy),
      .o_done(o_done), .o_error(o_error), .o_words_loaded(o_words_loaded)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Monitor: compares every write and every done/error pulse against the queues
   initial begin
      logic [AW+IW-1:0] e_wr;
      logic [AW+2:0]    e_ev;
      logic             prev_we;
      prev_we = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_we = 1'b0;
         end else begin
            if (o_pm_we != 4'b0000) begin
               n_we++;
               chk("pm_we_value", 32'(o_pm_we), 32'h0000000F);
               chk("single_we_cycle", 32'(prev_we), 32'h0);
               if (exp_wr.size() == 0) begin
                  fail_now("unexpected_write");
               end else begin
                  e_wr = exp_wr.pop_front();
                  chk("pm_addr", 32'(o_pm_addr), 32'(e_wr[AW+IW-1:IW]));
                  chk("pm_wdata", 32'(o_pm_wdata), 32'(e_wr[IW-1:0]));
               end
            end
            prev_we = (o_pm_we != 4'b0000);
            if (o_done || o_error) begin
               if (exp_ev.size() == 0) begin
                  fail_now("unexpected_done_error");
               end else begin
                  e_ev = exp_ev.pop_front();
                  chk("done_error_words", 32'({o_done, o_error, o_words_loaded}), 32'(e_ev));
               end
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 50 && !o_rx_ready; i++) @(negedge clk);
      if (!o_rx_ready) begin
         fail_now("rx_ready_stuck_low");
         rx_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 rx_valid = 1'b0;
      end
   endtask

   task automatic send_fb();
      for (int i = 0; i < fb.size(); i++) send_byte(fb[i]);
   endtask

   task automatic wait_ev(input string name);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (o_done || o_error) return;
      end
      fail_now(name);
   endtask

   initial begin
      int we_before;
      int k;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_rx_ready", 32'(o_rx_ready), 32'h1);
      chk("rst_pm_we", 32'(o_pm_we), 32'h0);
      chk("rst_pm_addr", 32'(o_pm_addr), 32'h0);
      chk("rst_pm_wdata", 32'(o_pm_wdata), 32'h0);
      chk("rst_flags", 32'({o_cpu_reset, o_busy, o_done, o_error}), 32'h0);
      chk("rst_words", 32'(o_words_loaded), 32'h0);
      rst_n = 1'b1;

      // 1: three-word frame, good checksum
      exp_wr.push_back({10'd0, 18'h3FF00});
      exp_wr.push_back({10'd1, 18'h00102});
      exp_wr.push_back({10'd2, 18'h2A5A5});
      exp_ev.push_back({1'b1, 1'b0, 11'd3});
      send_byte(8'hA5);
      @(negedge clk);
      chk("t1_busy_cpu_after_sync", 32'({o_busy, o_cpu_reset}), 32'h3);
      fb = '{8'h00, 8'h02, 8'h03, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h02,
             8'h02, 8'hA5, 8'hA5, 8'hAF};
      send_fb();
      wait_ev("t1_no_done");
      chk("t1_cpu_busy_cleared", 32'({o_cpu_reset, o_busy}), 32'h0);
      @(negedge clk);
      chk("t1_done_one_cycle", 32'(o_done), 32'h0);

      // 2: same frame, checksum off by one
      exp_wr.push_back({10'd0, 18'h3FF00});
      exp_wr.push_back({10'd1, 18'h00102});
      exp_wr.push_back({10'd2, 18'h2A5A5});
      exp_ev.push_back({1'b0, 1'b1, 11'd3});
      fb = '{8'hA5, 8'h00, 8'h02, 8'h03, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h02,
             8'h02, 8'hA5, 8'hA5, 8'hB0};
      send_fb();
      wait_ev("t2_no_error");
      @(negedge clk);
      chk("t2_cpu_held_busy_low", 32'({o_cpu_reset, o_busy}), 32'h2);

      // 3: LEN = 1024 is rejected before any write
      we_before = n_we;
      exp_ev.push_back({1'b0, 1'b1, 11'd0});
      fb = '{8'hA5, 8'h04, 8'h00};
      send_fb();
      wait_ev("t3_no_error");
      repeat (3) @(negedge clk);
      chk("t3_no_writes", 32'(n_we - we_before), 32'h0);
      chk("t3_idle_ready", 32'({o_rx_ready, o_busy, o_cpu_reset}), 32'h5);

      // 4: timeout mid-word, 16 cycles after the last handshake
      exp_ev.push_back({1'b0, 1'b1, 11'd0});
      fb = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'hFF};
      send_fb();
      k = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (o_error) begin
            k = c;
            break;
         end
      end
      chk("t4_timeout_cycle", 32'(k), 32'd16);
      chk("t4_cpu_held", 32'(o_cpu_reset), 32'h1);

      // 5: garbage before a one-word frame (b0 upper bits ignored)
      exp_wr.push_back({10'd0, 18'h11234});
      exp_ev.push_back({1'b1, 1'b0, 11'd1});
      fb = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'hFD, 8'h12, 8'h34, 8'hBD};
      send_fb();
      wait_ev("t5_no_done");
      chk("t5_cpu_released", 32'(o_cpu_reset), 32'h0);

      // 6: reset while in B1 of word 5, then a fresh load
      fb = '{8'hA5, 8'h00, 8'h07};
      send_fb();
      for (int w = 0; w < 5; w++) begin
         exp_wr.push_back({10'(w), 2'b01, 8'(w), 8'(8'h10 + w)});
         send_byte(8'h01);
         send_byte(8'(w));
         send_byte(8'(8'h10 + w));
      end
      send_byte(8'h01);
      @(negedge clk);
      chk("t6_busy_before_reset", 32'({o_busy, o_cpu_reset}), 32'h3);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_rst_rx_ready", 32'(o_rx_ready), 32'h1);
      chk("t6_rst_pm", 32'({o_pm_we, o_pm_addr}), 32'h0);
      chk("t6_rst_wdata", 32'(o_pm_wdata), 32'h0);
      chk("t6_rst_flags", 32'({o_cpu_reset, o_busy, o_done, o_error}), 32'h0);
      chk("t6_rst_words", 32'(o_words_loaded), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_wr.push_back({10'd0, 18'h12345});
      exp_ev.push_back({1'b1, 1'b0, 11'd1});
      fb = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h23, 8'h45, 8'h97};
      send_fb();
      wait_ev("t6_no_done");
      repeat (3) @(negedge clk);

      chk("writes_all_seen", 32'(exp_wr.size()), 32'h0);
      chk("events_all_seen", 32'(exp_ev.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
